// File: rtl/int_to_fp_pipe.sv
// Integer / raw-bit-pattern to recoded-float converter (FCVT.{S,D}.{W,WU,L,LU}, FMV.{W,D}.X)
// behind a STAGES-deep valid/ready pipe. Define INT2FP_PERF_EN to add fcvt/inexact counters.
module int_to_fp_pipe #(
    parameter int STAGES = 2,
    parameter int TAG_W  = 5
) (
    input  logic             clk,
    input  logic             rst_l,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [63:0]      in_rs1,
    input  logic [2:0]       in_rm,
    input  logic [2:0]       in_frm,
    input  logic             in_fp64,
    input  logic [3:0]       in_ctrl,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [64:0]      out_data,
    output logic [4:0]       out_exc,
    output logic             out_illegal_rm,
    output logic [TAG_W-1:0] out_tag
`ifdef INT2FP_PERF_EN
    ,
    output logic [31:0]      perf_cvt_cnt,
    output logic [31:0]      perf_nx_cnt
`endif
);

    typedef struct packed {
        logic [64:0]      data;
        logic [4:0]       exc;
        logic             ill;
        logic [TAG_W-1:0] tag;
`ifdef INT2FP_PERF_EN
        logic             cvt;
`endif
    } pay_t;

    // IEEE single -> 33-bit recoded; zero is emitted with a fully clear exponent.
    function automatic logic [32:0] rec_s(input logic [31:0] f);
        logic [22:0] fr, sf;
        logic [7:0]  ex;
        logic [8:0]  ae;
        logic [4:0]  nd;
        logic        ze, zf, spec;
        fr = f[22:0];
        ex = f[30:23];
        ze = (ex == '0);
        zf = (fr == '0);
        nd = '0;
        for (int i = 0; i < 23; i++) if (fr[i]) nd = 5'(22 - i);
        sf = fr << (nd + 5'd1);
        ae = (ze ? ~{4'b0, nd} : {1'b0, ex}) + (ze ? 9'h082 : 9'h081);
        spec = (ae[8:7] == 2'b11);
        if (ze && zf) ae = '0;
        else if (spec) ae[6] = ~zf;
        return {f[31], ae, ze ? sf : fr};
    endfunction

    function automatic logic [64:0] rec_d(input logic [63:0] f);
        logic [51:0] fr, sf;
        logic [10:0] ex;
        logic [11:0] ae;
        logic [5:0]  nd;
        logic        ze, zf, spec;
        fr = f[51:0];
        ex = f[62:52];
        ze = (ex == '0);
        zf = (fr == '0);
        nd = '0;
        for (int i = 0; i < 52; i++) if (fr[i]) nd = 6'(51 - i);
        sf = fr << (nd + 6'd1);
        ae = (ze ? ~{6'b0, nd} : {1'b0, ex}) + (ze ? 12'h402 : 12'h401);
        spec = (ae[11:10] == 2'b11);
        if (ze && zf) ae = '0;
        else if (spec) ae[9] = ~zf;
        return {f[63], ae, ze ? sf : fr};
    endfunction

    logic [2:0]  rm;
    logic [63:0] src, mag, norm;
    logic [5:0]  lz;
    logic        neg, lsb, grd, stk, inc, nx;
    logic [23:0] fsum_s;
    logic [52:0] fsum_d;
    logic [64:0] cvt_data;
    pay_t        pay_d;

    always_comb begin
        rm   = (in_rm == 3'b111) ? in_frm : in_rm;
        src  = in_ctrl[0] ? in_rs1
             : (in_ctrl[1] ? {{32{in_rs1[31]}}, in_rs1[31:0]} : {32'b0, in_rs1[31:0]});
        neg  = in_ctrl[1] & src[63];
        mag  = neg ? (64'd0 - src) : src;
        lz   = '0;
        for (int i = 0; i < 64; i++) if (mag[i]) lz = 6'(63 - i);
        norm = mag << lz;
        if (in_fp64) begin
            lsb = norm[11]; grd = norm[10]; stk = |norm[9:0];
        end else begin
            lsb = norm[40]; grd = norm[39]; stk = |norm[38:0];
        end
        case (rm)
            3'b000:  inc = grd & (stk | lsb);
            3'b010:  inc = neg & (grd | stk);
            3'b011:  inc = ~neg & (grd | stk);
            3'b100:  inc = grd;
            default: inc = 1'b0;
        endcase
        nx = grd | stk;
        // Hidden bit is always 1, so a carry out of the fraction is exactly the
        // round-up-to-next-binade case and the wrapped fraction is already zero.
        fsum_s = {1'b0, norm[62:40]} + 24'(inc);
        fsum_d = {1'b0, norm[62:11]} + 53'(inc);
        if (!norm[63])
            cvt_data = '0;
        else if (in_fp64)
            cvt_data = {neg, 12'h83F - 12'(lz) + 12'(fsum_d[52]), fsum_d[51:0]};
        else
            cvt_data = {32'b0, neg, 9'h13F - 9'(lz) + 9'(fsum_s[23]), fsum_s[22:0]};

        pay_d     = '0;
        pay_d.tag = in_tag;
        if (in_ctrl[3]) begin
`ifdef INT2FP_PERF_EN
            pay_d.cvt = 1'b1;
`endif
            if (rm[2] & (rm[1] | rm[0])) begin
                pay_d.ill = 1'b1;
            end else begin
                pay_d.data = cvt_data;
                pay_d.exc  = {4'b0, nx};
            end
        end else if (in_ctrl[2]) begin
            pay_d.data = in_fp64 ? rec_d(in_rs1) : {32'b0, rec_s(in_rs1[31:0])};
        end
    end

    logic [STAGES:1] vld_q;
    pay_t            pay_q [1:STAGES];
    logic [STAGES:0] adv;

    // A stage may take new data when it is empty or its contents move on this cycle.
    always_comb begin
        adv[STAGES] = out_ready;
        for (int i = STAGES - 1; i >= 0; i--) adv[i] = ~vld_q[i+1] | adv[i+1];
    end

    always_ff @(posedge clk) begin
        if (!rst_l) begin
            vld_q <= '0;
            for (int i = 1; i <= STAGES; i++) pay_q[i] <= '0;
        end else begin
            if (adv[0]) begin
                vld_q[1] <= in_valid;
                pay_q[1] <= pay_d;
            end
            for (int i = 2; i <= STAGES; i++) begin
                if (adv[i-1]) begin
                    vld_q[i] <= vld_q[i-1];
                    pay_q[i] <= pay_q[i-1];
                end
            end
            if (flush) vld_q <= '0;
        end
    end

    assign in_ready       = adv[0];
    assign out_valid      = vld_q[STAGES];
    assign out_data       = pay_q[STAGES].data;
    assign out_exc        = pay_q[STAGES].exc;
    assign out_illegal_rm = pay_q[STAGES].ill;
    assign out_tag        = pay_q[STAGES].tag;

`ifdef INT2FP_PERF_EN
    always_ff @(posedge clk) begin
        if (!rst_l) begin
            perf_cvt_cnt <= '0;
            perf_nx_cnt  <= '0;
        end else if (out_valid && out_ready && pay_q[STAGES].cvt) begin
            perf_cvt_cnt <= perf_cvt_cnt + 32'd1;
            if (pay_q[STAGES].exc[0]) perf_nx_cnt <= perf_nx_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_int_to_fp_pipe.sv
// Directed bench for int_to_fp_pipe: conversions, fmv recoding, illegal rm,
// backpressure ordering, flush and mid-stream reset.
module tb_int_to_fp_pipe;
    localparam int S  = 2;
    localparam int TW = 5;

    logic          clk = 1'b0;
    logic          rst_l, flush, in_valid, in_ready, in_fp64, out_valid, out_ready, out_illegal_rm;
    logic [63:0]   in_rs1;
    logic [2:0]    in_rm, in_frm;
    logic [3:0]    in_ctrl;
    logic [TW-1:0] in_tag, out_tag;
    logic [64:0]   out_data;
    logic [4:0]    out_exc;
`ifdef INT2FP_PERF_EN
    logic [31:0]   perf_cvt_cnt, perf_nx_cnt;
`endif

    int ncmp = 0;
    int nfail = 0;
    int k, nrecv;
    logic [64:0] bp_exp [4];

    always #5 clk = ~clk;

    int_to_fp_pipe #(.STAGES(S), .TAG_W(TW)) dut (
        .clk(clk), .rst_l(rst_l), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_rs1(in_rs1),
        .in_rm(in_rm), .in_frm(in_frm), .in_fp64(in_fp64), .in_ctrl(in_ctrl), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_exc(out_exc),
        .out_illegal_rm(out_illegal_rm), .out_tag(out_tag)
`ifdef INT2FP_PERF_EN
        , .perf_cvt_cnt(perf_cvt_cnt), .perf_nx_cnt(perf_nx_cnt)
`endif
    );

    task automatic chk(input string name, input logic [64:0] obs, input logic [64:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: got %0h expected %0h", name, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [63:0] rs1, input logic [2:0] rm, input logic [2:0] frm,
                         input logic fp64, input logic [3:0] ctrl, input logic [TW-1:0] tag);
        in_valid = v; in_rs1 = rs1; in_rm = rm; in_frm = frm;
        in_fp64 = fp64; in_ctrl = ctrl; in_tag = tag;
    endtask

    // Single op through an empty pipe with out_ready high; checks exact latency.
    task automatic run1(input string name, input logic [63:0] rs1, input logic [2:0] rm, input logic [2:0] frm,
                        input logic fp64, input logic [3:0] ctrl, input logic [TW-1:0] tag,
                        input logic [64:0] ed, input logic [4:0] ee, input logic eill);
        drive(1'b1, rs1, rm, frm, fp64, ctrl, tag);
        #1;
        chk({name, ".rdy"}, 65'(in_ready), 65'd1);
        tick();
        in_valid = 1'b0;
        for (int i = 1; i < S; i++) begin
            chk({name, ".early"}, 65'(out_valid), 65'd0);
            tick();
        end
        chk({name, ".vld"}, 65'(out_valid), 65'd1);
        chk({name, ".data"}, out_data, ed);
        chk({name, ".exc"}, 65'(out_exc), 65'(ee));
        chk({name, ".ill"}, 65'(out_illegal_rm), 65'(eill));
        chk({name, ".tag"}, 65'(out_tag), 65'(tag));
        tick();
        chk({name, ".gone"}, 65'(out_valid), 65'd0);
    endtask

    initial begin
        bp_exp[0] = 65'h0_8000_0000; bp_exp[1] = 65'h0_8080_0000;
        bp_exp[2] = 65'h0_80C0_0000; bp_exp[3] = 65'h0_8100_0000;
        rst_l = 1'b0; flush = 1'b0; out_ready = 1'b1;
        drive(1'b0, 64'd0, 3'd0, 3'd0, 1'b0, 4'd0, '0);
        tick(); tick();
        chk("rst.vld", 65'(out_valid), 65'd0);
        chk("rst.data", out_data, 65'd0);
        chk("rst.exc", 65'(out_exc), 65'd0);
        chk("rst.tag", 65'(out_tag), 65'd0);
        chk("rst.ill", 65'(out_illegal_rm), 65'd0);
        chk("rst.rdy", 65'(in_ready), 65'd1);
        rst_l = 1'b1;
        tick();

        // ctrl = {fcvt, fmv, sign, long}
        run1("s_w_1",    64'd1,                   3'd0, 3'd0, 1'b0, 4'b1010, 5'd3,  65'h0_8000_0000, 5'd0, 1'b0);
        run1("s_w_rne",  64'h0100_0001,           3'd0, 3'd0, 1'b0, 4'b1010, 5'd4,  65'h0_8C00_0000, 5'd1, 1'b0);
        run1("s_w_dyn",  64'h0100_0001,           3'd7, 3'd3, 1'b0, 4'b1010, 5'd5,  65'h0_8C00_0001, 5'd1, 1'b0);
        run1("s_w_rmm",  64'h0100_0001,           3'd4, 3'd0, 1'b0, 4'b1010, 5'd6,  65'h0_8C00_0001, 5'd1, 1'b0);
        run1("s_w_rdn",  64'hFEFF_FFFF,           3'd2, 3'd0, 1'b0, 4'b1010, 5'd7,  65'h1_8C00_0001, 5'd1, 1'b0);
        run1("s_w_rup",  64'hFEFF_FFFF,           3'd3, 3'd0, 1'b0, 4'b1010, 5'd8,  65'h1_8C00_0000, 5'd1, 1'b0);
        run1("s_w_neg",  64'hFFFF_FFFF,           3'd0, 3'd0, 1'b0, 4'b1010, 5'd9,  65'h1_8000_0000, 5'd0, 1'b0);
        run1("s_w_hi",   64'hDEAD_BEEF_0000_0001, 3'd0, 3'd0, 1'b0, 4'b1010, 5'd10, 65'h0_8000_0000, 5'd0, 1'b0);
        run1("s_wu_rne", 64'hFFFF_FFFF,           3'd0, 3'd0, 1'b0, 4'b1000, 5'd11, 65'h0_9000_0000, 5'd1, 1'b0);
        run1("s_wu_rtz", 64'hFFFF_FFFF,           3'd1, 3'd0, 1'b0, 4'b1000, 5'd12, 65'h0_8FFF_FFFF, 5'd1, 1'b0);
        run1("s_l",      64'h0000_0001_0000_0000, 3'd0, 3'd0, 1'b0, 4'b1011, 5'd13, 65'h0_9000_0000, 5'd0, 1'b0);
        run1("d_l_1",    64'd1,                   3'd0, 3'd0, 1'b1, 4'b1011, 5'd14, 65'h0_8000_0000_0000_0000, 5'd0, 1'b0);
        run1("d_x_mv",   64'h3FF0_0000_0000_0000, 3'd0, 3'd0, 1'b1, 4'b0100, 5'd15, 65'h0_8000_0000_0000_0000, 5'd0, 1'b0);
        run1("d_lu_max", 64'hFFFF_FFFF_FFFF_FFFF, 3'd0, 3'd0, 1'b1, 4'b1001, 5'd16, 65'h0_8400_0000_0000_0000, 5'd1, 1'b0);
        run1("d_l_min",  64'h8000_0000_0000_0000, 3'd0, 3'd0, 1'b1, 4'b1011, 5'd17, 65'h1_83F0_0000_0000_0000, 5'd0, 1'b0);
        run1("d_l_zero", 64'd0,                   3'd0, 3'd0, 1'b1, 4'b1011, 5'd18, 65'h0, 5'd0, 1'b0);
        run1("d_w_neg",  64'hFFFF_FFFF,           3'd0, 3'd0, 1'b1, 4'b1010, 5'd19, 65'h1_8000_0000_0000_0000, 5'd0, 1'b0);
        run1("ill_101",  64'h0100_0001,           3'd5, 3'd0, 1'b0, 4'b1010, 5'd20, 65'h0, 5'd0, 1'b1);
        run1("ill_dyn",  64'h0100_0001,           3'd7, 3'd6, 1'b0, 4'b1010, 5'd21, 65'h0, 5'd0, 1'b1);
        run1("mv_badrm", 64'hFFFF_FFFF_3F80_0000, 3'd5, 3'd0, 1'b0, 4'b0100, 5'd22, 65'h0_8000_0000, 5'd0, 1'b0);
        run1("mv_sub",   64'd1,                   3'd0, 3'd0, 1'b0, 4'b0100, 5'd23, 65'h0_3580_0000, 5'd0, 1'b0);
        run1("mv_nan",   64'h7FC0_0000,           3'd0, 3'd0, 1'b0, 4'b0100, 5'd24, 65'h0_E040_0000, 5'd0, 1'b0);
        run1("mv_negz",  64'h8000_0000,           3'd0, 3'd0, 1'b0, 4'b0100, 5'd25, 65'h1_0000_0000, 5'd0, 1'b0);
        run1("mv_dsub",  64'd1,                   3'd0, 3'd0, 1'b1, 4'b0100, 5'd26, 65'h0_3CE0_0000_0000_0000, 5'd0, 1'b0);
        run1("mv_dinf",  64'h7FF0_0000_0000_0000, 3'd0, 3'd0, 1'b1, 4'b0100, 5'd27, 65'h0_C000_0000_0000_0000, 5'd0, 1'b0);
        run1("both",     64'd1,                   3'd0, 3'd0, 1'b0, 4'b1110, 5'd28, 65'h0_8000_0000, 5'd0, 1'b0);
        run1("none",     64'd1,                   3'd0, 3'd0, 1'b0, 4'b0010, 5'd29, 65'h0, 5'd0, 1'b0);

        // Backpressure: 4 back-to-back ops, consumer stalled for 5 cycles.
        out_ready = 1'b0; k = 0; nrecv = 0;
        for (int c = 0; c < 30 && nrecv < 4; c++) begin
            if (c == 5) out_ready = 1'b1;
            if (k < 4) drive(1'b1, 64'(k + 1), 3'd0, 3'd0, 1'b0, 4'b1010, TW'(10 + k));
            else in_valid = 1'b0;
            #1;
            if (c >= S && c < 5) begin
                chk("bp.rdy", 65'(in_ready), 65'd0);
                chk("bp.hold_v", 65'(out_valid), 65'd1);
                chk("bp.hold_tag", 65'(out_tag), 65'd10);
                chk("bp.hold_data", out_data, bp_exp[0]);
            end
            if (c == 4) chk("bp.buffered", 65'(k), 65'(S));
            if (out_valid && out_ready && nrecv < 4) begin
                chk("bp.tag", 65'(out_tag), 65'(10 + nrecv));
                chk("bp.data", out_data, bp_exp[nrecv]);
                nrecv++;
            end
            if (in_valid && in_ready) k++;
            tick();
        end
        in_valid = 1'b0;
        chk("bp.recv", 65'(nrecv), 65'd4);
        chk("bp.sent", 65'(k), 65'd4);
        for (int i = 0; i < S + 1; i++) begin
            chk("bp.nodup", 65'(out_valid), 65'd0);
            tick();
        end

        // Flush with the pipe full and stalled.
        out_ready = 1'b0;
        drive(1'b1, 64'd1, 3'd0, 3'd0, 1'b0, 4'b1010, 5'd20); tick();
        drive(1'b1, 64'd2, 3'd0, 3'd0, 1'b0, 4'b1010, 5'd21); tick();
        in_valid = 1'b0; flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("fl.full_v", 65'(out_valid), 65'd0);
        out_ready = 1'b1;
        for (int i = 0; i < S + 2; i++) begin
            tick();
            chk("fl.full_gone", 65'(out_valid), 65'd0);
        end

        // Flush with one op in flight and one accepted in the flush cycle.
        drive(1'b1, 64'd3, 3'd0, 3'd0, 1'b0, 4'b1010, 5'd22); tick();
        drive(1'b1, 64'd4, 3'd0, 3'd0, 1'b0, 4'b1010, 5'd23); flush = 1'b1;
        #1;
        chk("fl.rdy", 65'(in_ready), 65'd1);
        tick();
        flush = 1'b0; in_valid = 1'b0;
        for (int i = 0; i < S + 2; i++) begin
            chk("fl.part_gone", 65'(out_valid), 65'd0);
            tick();
        end
        run1("post_flush", 64'd1, 3'd0, 3'd0, 1'b0, 4'b1010, 5'd7, 65'h0_8000_0000, 5'd0, 1'b0);

        // Mid-stream reset with held, nonzero output.
        out_ready = 1'b0;
        drive(1'b1, 64'h0100_0001, 3'd0, 3'd0, 1'b0, 4'b1010, 5'd9);  tick();
        drive(1'b1, 64'h0100_0001, 3'd5, 3'd0, 1'b0, 4'b1010, 5'd10); tick();
        in_valid = 1'b0;
        chk("mr.pre_v", 65'(out_valid), 65'd1);
        chk("mr.pre_tag", 65'(out_tag), 65'd9);
        rst_l = 1'b0;
        tick();
        rst_l = 1'b1;
        chk("mr.vld", 65'(out_valid), 65'd0);
        chk("mr.data", out_data, 65'd0);
        chk("mr.exc", 65'(out_exc), 65'd0);
        chk("mr.tag", 65'(out_tag), 65'd0);
        chk("mr.ill", 65'(out_illegal_rm), 65'd0);
        out_ready = 1'b1;
        for (int i = 0; i < S + 1; i++) begin
            tick();
            chk("mr.gone", 65'(out_valid), 65'd0);
        end
        run1("post_rst", 64'h0100_0001, 3'd3, 3'd0, 1'b0, 4'b1010, 5'd1, 65'h0_8C00_0001, 5'd1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end
endmodule
